// File: rtl/hbm_bench_sequencer.sv
// hbm_bench_sequencer: sweeps enabled HBM lt_engine channels one at a time,
// running write then read phases with a per-phase timeout and reporting sums.
module hbm_bench_sequencer #(
  parameter int N_MEM_INTF = 32,
  parameter int CH_BITS    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_start,
  input  logic                       cmd_abort,
  input  logic [N_MEM_INTF-1:0]      cmd_chan_mask,
  input  logic [1:0]                 cmd_mode,
  input  logic [31:0]                cmd_timeout,
  output logic [N_MEM_INTF-1:0]      ld_params_wr,
  output logic [N_MEM_INTF-1:0]      ld_params_rd,
  output logic [N_MEM_INTF-1:0]      start_wr,
  output logic [N_MEM_INTF-1:0]      start_rd,
  input  logic [N_MEM_INTF-1:0]      end_wr,
  input  logic [N_MEM_INTF-1:0]      end_rd,
  input  logic [N_MEM_INTF*64-1:0]   lat_timer_sum_wr,
  input  logic [N_MEM_INTF*64-1:0]   lat_timer_sum_rd,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic                       res_valid,
  output logic [CH_BITS-1:0]         res_chan,
  output logic [63:0]                res_wr_cycles,
  output logic [63:0]                res_rd_cycles,
  output logic [1:0]                 res_timeout,
  output logic [CH_BITS:0]           res_count
);

  typedef enum logic [3:0] {
    IDLE, SCAN, LOAD, STW, WTW, STR, WTR, REPORT, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_BITS-1:0]      ch_q, ch_d;
  logic [N_MEM_INTF-1:0]   mask_q, mask_d;
  logic [1:0]              mode_q, mode_d;
  logic [31:0]             tmo_q, tmo_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [N_MEM_INTF-1:0]   ld_q, ld_d;
  logic [N_MEM_INTF-1:0]   st_wr_q, st_wr_d;
  logic [N_MEM_INTF-1:0]   st_rd_q, st_rd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    rv_q, rv_d;
  logic [CH_BITS-1:0]      rchan_q, rchan_d;
  logic [63:0]             rwr_q, rwr_d;
  logic [63:0]             rrd_q, rrd_d;
  logic [1:0]              rto_q, rto_d;
  logic [CH_BITS:0]        rcnt_q, rcnt_d;

  logic [N_MEM_INTF-1:0]   scan_m;
  logic [N_MEM_INTF-1:0]   oh;
  logic [CH_BITS-1:0]      scan_idx;
  logic                    tmo_hit;
  logic [63:0]             sum_wr;
  logic [63:0]             sum_rd;

  assign sum_wr = lat_timer_sum_wr[{ch_q, 6'd0} +: 64];
  assign sum_rd = lat_timer_sum_rd[{ch_q, 6'd0} +: 64];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    tmo_d     = tmo_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    aborted_d = aborted_q;
    rchan_d   = rchan_q;
    rwr_d     = rwr_q;
    rrd_d     = rrd_q;
    rto_d     = rto_q;
    rcnt_d    = rcnt_q;
    scan_m    = mask_q & ({N_MEM_INTF{1'b1}} << ch_q);
    scan_idx  = '0;
    for (int i = N_MEM_INTF - 1; i >= 0; i--)
      if (scan_m[i]) scan_idx = CH_BITS'(i);
    // counter holds timeout-1 on the last allowed wait cycle
    tmo_hit   = (tmo_q != '0) && (cnt_q == tmo_q - 32'd1);

    if (cmd_abort && state_q != IDLE && state_q != DONE) begin
      state_d   = DONE;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_start) begin
            mask_d    = cmd_chan_mask;
            mode_d    = cmd_mode;
            tmo_d     = cmd_timeout;
            ch_d      = '0;
            rcnt_d    = '0;
            aborted_d = 1'b0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          if (scan_m == '0 || mode_q == 2'b00) begin
            state_d = DONE;
          end else begin
            ch_d    = scan_idx;
            state_d = LOAD;
          end
        end
        LOAD: state_d = mode_q[0] ? STW : STR;
        STW: begin
          cnt_d   = '0;
          state_d = WTW;
        end
        WTW: begin
          if (end_wr[ch_q]) begin
            rwr_d   = sum_wr;
            state_d = mode_q[1] ? STR : REPORT;
          end else if (tmo_hit) begin
            rto_d[0] = 1'b1;
            state_d  = mode_q[1] ? STR : REPORT;
          end
        end
        STR: begin
          cnt_d   = '0;
          state_d = WTR;
        end
        WTR: begin
          if (end_rd[ch_q]) begin
            rrd_d   = sum_rd;
            state_d = REPORT;
          end else if (tmo_hit) begin
            rto_d[1] = 1'b1;
            state_d  = REPORT;
          end
        end
        REPORT: begin
          if (ch_q == CH_BITS'(N_MEM_INTF - 1)) begin
            state_d = DONE;
          end else begin
            ch_d    = ch_q + {{(CH_BITS-1){1'b0}}, 1'b1};
            state_d = SCAN;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // outputs are registered against the state being entered
    oh      = {{(N_MEM_INTF-1){1'b0}}, 1'b1} << ch_d;
    ld_d    = (state_d == LOAD) ? oh : '0;
    st_wr_d = (state_d == STW) ? oh : '0;
    st_rd_d = (state_d == STR) ? oh : '0;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    rv_d    = state_d == REPORT;
    if (state_d == LOAD) begin
      rwr_d = '0;
      rrd_d = '0;
      rto_d = '0;
    end
    if (state_d == REPORT) begin
      rchan_d = ch_d;
      rcnt_d  = rcnt_q + {{CH_BITS{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      ld_q      <= '0;
      st_wr_q   <= '0;
      st_rd_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rv_q      <= 1'b0;
      rchan_q   <= '0;
      rwr_q     <= '0;
      rrd_q     <= '0;
      rto_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      ld_q      <= ld_d;
      st_wr_q   <= st_wr_d;
      st_rd_q   <= st_rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      rv_q      <= rv_d;
      rchan_q   <= rchan_d;
      rwr_q     <= rwr_d;
      rrd_q     <= rrd_d;
      rto_q     <= rto_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign ld_params_wr  = ld_q;
  assign ld_params_rd  = ld_q;
  assign start_wr      = st_wr_q;
  assign start_rd      = st_rd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign res_valid     = rv_q;
  assign res_chan      = rchan_q;
  assign res_wr_cycles = rwr_q;
  assign res_rd_cycles = rrd_q;
  assign res_timeout   = rto_q;
  assign res_count     = rcnt_q;

endmodule

// File: tb/tb_hbm_bench_sequencer.sv
// Bench for hbm_bench_sequencer: a procedural sweep script predicts every
// output cycle by cycle and also plays the engines; literal checks pin it.
module tb_hbm_bench_sequencer;
  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_start = 1'b0;
  logic            cmd_abort = 1'b0;
  logic [N-1:0]    cmd_chan_mask = '0;
  logic [1:0]      cmd_mode = '0;
  logic [31:0]     cmd_timeout = '0;
  logic [N-1:0]    ld_params_wr, ld_params_rd, start_wr, start_rd;
  logic [N-1:0]    end_wr = '0;
  logic [N-1:0]    end_rd = '0;
  logic [N*64-1:0] lat_wr, lat_rd;
  logic            busy, done, aborted, res_valid;
  logic [4:0]      res_chan;
  logic [63:0]     res_wr_cycles, res_rd_cycles;
  logic [1:0]      res_timeout;
  logic [5:0]      res_count;

  hbm_bench_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_chan_mask(cmd_chan_mask), .cmd_mode(cmd_mode),
    .cmd_timeout(cmd_timeout),
    .ld_params_wr(ld_params_wr), .ld_params_rd(ld_params_rd),
    .start_wr(start_wr), .start_rd(start_rd),
    .end_wr(end_wr), .end_rd(end_rd),
    .lat_timer_sum_wr(lat_wr), .lat_timer_sum_rd(lat_rd),
    .busy(busy), .done(done), .aborted(aborted),
    .res_valid(res_valid), .res_chan(res_chan),
    .res_wr_cycles(res_wr_cycles), .res_rd_cycles(res_rd_cycles),
    .res_timeout(res_timeout), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int cc = 0;
  always @(posedge clk) cc <= cc + 1;

  // engine behaviour: per-channel sums and end delays (0 = never ends)
  logic [63:0] sw[N];
  logic [63:0] sr[N];
  int          dw[N];
  int          dr[N];
  always_comb
    for (int c = 0; c < N; c++) begin
      lat_wr[c*64 +: 64] = sw[c];
      lat_rd[c*64 +: 64] = sr[c];
    end

  // expected outputs for the current cycle
  logic [31:0] e_ld = '0, e_stw = '0, e_str = '0;
  logic        e_busy = 0, e_done = 0, e_ab = 0, e_rv = 0;
  logic [4:0]  e_chan = '0;
  logic [63:0] e_wr = '0, e_rd = '0;
  logic [1:0]  e_to = '0;
  logic [5:0]  e_cnt = '0;
  int          p_kind = 0;
  logic [63:0] p_val;

  int nvec = 0, nbad = 0;
  int ch, cur_ch = -1, cyc, abort_at, rst_at, cur_to;
  bit ab, rs, busy_m = 0;

  typedef struct {
    logic [4:0] c; logic [63:0] w; logic [63:0] r; logic [1:0] t;
  } res_t;
  res_t        rq[$];
  int          n_done, n_stw, n_str, n_ld, t_done, t_stw, t_to, t_start;
  logic [31:0] last_stw;
  logic        prev_to0 = 0;

  task automatic cmp(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      if (nbad < 40)
        $display("FAIL %s: got %0h expected %0h cycle %0d", nm, a, e, cc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp("ld_params_wr", ld_params_wr, e_ld);
    cmp("ld_params_rd", ld_params_rd, e_ld);
    cmp("start_wr", start_wr, e_stw);
    cmp("start_rd", start_rd, e_str);
    cmp("busy", busy, e_busy);
    cmp("done", done, e_done);
    cmp("aborted", aborted, e_ab);
    cmp("res_valid", res_valid, e_rv);
    cmp("res_chan", res_chan, e_chan);
    cmp("res_wr_cycles", res_wr_cycles, e_wr);
    cmp("res_rd_cycles", res_rd_cycles, e_rd);
    cmp("res_timeout", res_timeout, e_to);
    cmp("res_count", res_count, e_cnt);
    if (res_valid)
      rq.push_back('{res_chan, res_wr_cycles, res_rd_cycles, res_timeout});
    if (done) begin n_done++; t_done = cc; end
    if (start_wr != 0) begin n_stw++; t_stw = cc; last_stw = start_wr; end
    if (start_rd != 0) n_str++;
    if (ld_params_wr != 0) n_ld++;
    if (res_timeout[0] && !prev_to0) t_to = cc;
    prev_to0 = res_timeout[0];
  end

  task automatic clear_mon();
    rq.delete();
    n_done = 0; n_stw = 0; n_str = 0; n_ld = 0;
    t_done = 0; t_stw = 0; t_to = 0; last_stw = '0;
  endtask

  // advance to the next cycle: drop pulses, apply last cycle's capture,
  // and put noise on the engine ends and junk on the command inputs
  task automatic tick();
    logic [31:0] nz;
    @(posedge clk); #1;
    cyc++;
    e_ld = '0; e_stw = '0; e_str = '0; e_done = 0; e_rv = 0;
    case (p_kind)
      1: e_wr = p_val;
      2: e_rd = p_val;
      3: e_to[0] = 1'b1;
      4: e_to[1] = 1'b1;
      default: ;
    endcase
    p_kind = 0;
    rst = 0;
    nz = $urandom;
    if (cur_ch >= 0) nz[cur_ch] = 1'b0;
    end_wr = nz;
    nz = $urandom;
    if (cur_ch >= 0) nz[cur_ch] = 1'b0;
    end_rd = nz;
    cmd_chan_mask = $urandom;
    cmd_mode = 2'($urandom);
    cmd_timeout = $urandom_range(0, 9);
    if (busy_m) begin
      cmd_start = ($urandom % 3 == 0);
      cmd_abort = 0;
    end else begin
      cmd_start = 0;
      cmd_abort = $urandom % 2;
    end
  endtask

  task automatic chk();
    if (cyc == abort_at) begin cmd_abort = 1; ab = 1; end
    else if (cyc == rst_at) begin rst = 1; rs = 1; end
  endtask

  task automatic phase(input bit rd);
    int d;
    d = rd ? dr[ch] : dw[ch];
    tick();
    if (rd) e_str = 32'd1 << ch; else e_stw = 32'd1 << ch;
    chk();
    if (ab || rs) return;
    for (int j = 1; j <= 400; j++) begin
      tick();
      chk();
      if (ab || rs) return;
      if (d == j) begin
        if (rd) begin end_rd[ch] = 1; p_kind = 2; p_val = sr[ch]; end
        else begin end_wr[ch] = 1; p_kind = 1; p_val = sw[ch]; end
        return;
      end
      if (cur_to != 0 && j == cur_to) begin
        p_kind = rd ? 4 : 3;
        return;
      end
    end
    nbad++;
    $display("FAIL phase_bound: chan %0d never finished", ch);
  endtask

  task automatic sweep(input logic [31:0] m, input logic [1:0] md,
                       input logic [31:0] to, input int ab_at,
                       input int rs_at);
    int nxt;
    tick();
    cmd_start = 1; cmd_chan_mask = m; cmd_mode = md; cmd_timeout = to;
    t_start = cc; cur_to = int'(to);
    abort_at = ab_at; rst_at = rs_at; ab = 0; rs = 0; cyc = 0;
    busy_m = 1;
    tick();
    e_busy = 1; e_ab = 0; e_cnt = 0;
    chk();
    ch = 0;
    while (!ab && !rs) begin
      nxt = -1;
      for (int i = ch; i < N; i++)
        if (m[i]) begin nxt = i; break; end
      if (nxt < 0 || md == 2'b00) break;
      ch = nxt; cur_ch = ch;
      tick();
      e_ld = 32'd1 << ch; e_wr = '0; e_rd = '0; e_to = '0;
      chk();
      if (ab || rs) break;
      if (md[0]) phase(0);
      if (ab || rs) break;
      if (md[1]) phase(1);
      if (ab || rs) break;
      tick();
      e_rv = 1; e_chan = 5'(ch); e_cnt = e_cnt + 6'd1;
      chk();
      if (ab || rs) break;
      if (ch == N - 1) break;
      ch++;
      tick();
      chk();
    end
    cur_ch = -1;
    if (rs) begin
      busy_m = 0;
      tick();
      e_busy = 0; e_ab = 0; e_chan = '0; e_wr = '0; e_rd = '0;
      e_to = '0; e_cnt = '0; p_kind = 0;
      return;
    end
    tick();
    e_done = 1;
    if (ab) e_ab = 1;
    cmd_abort = $urandom % 2;
    busy_m = 0;
    tick();
    e_busy = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m, to;
    int          aa, ra;
    for (int c = 0; c < N; c++) begin
      sw[c] = '0; sr[c] = '0; dw[c] = 1; dr[c] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", busy, 0);
    cmp("rst_res_count", res_count, 0);
    cmp("rst_start_wr", start_wr, 0);
    rst = 0;

    // two channels, both phases, fixed sums
    for (int c = 0; c < N; c++) begin
      sw[c] = 64'h10; sr[c] = 64'h20; dw[c] = 10; dr[c] = 10;
    end
    clear_mon();
    sweep(32'h5, 2'd3, 0, -1, -1);
    cmp("t1_nres", rq.size(), 2);
    cmp("t1_chan0", rq[0].c, 0);
    cmp("t1_chan1", rq[1].c, 2);
    cmp("t1_wr", rq[0].w, 64'h10);
    cmp("t1_rd", rq[1].r, 64'h20);
    cmp("t1_count", res_count, 2);
    cmp("t1_ndone", n_done, 1);

    // top channel only, write only
    for (int c = 0; c < N; c++) sw[c] = {$urandom, $urandom};
    clear_mon();
    sweep(32'h8000_0000, 2'd1, 0, -1, -1);
    cmp("t2_nstw", n_stw, 1);
    cmp("t2_stw", last_stw, 32'h8000_0000);
    cmp("t2_nstr", n_str, 0);
    cmp("t2_chan", rq[0].c, 31);
    cmp("t2_rd", rq[0].r, 0);

    // write never ends, 100-cycle timeout
    dw[0] = 0; dr[0] = 5;
    clear_mon();
    sweep(32'h1, 2'd3, 100, -1, -1);
    cmp("t3_to_delay", t_to - t_stw, 101);
    cmp("t3_res_to", rq[0].t, 1);
    cmp("t3_nstr", n_str, 1);

    // abort in the third write-wait cycle of channel 1
    for (int c = 0; c < N; c++) begin dw[c] = 8; dr[c] = 8; end
    clear_mon();
    sweep(32'h3, 2'd3, 0, 27, -1);
    cmp("t4_nres", rq.size(), 1);
    cmp("t4_chan", rq[0].c, 0);
    cmp("t4_nstr", n_str, 1);
    cmp("t4_aborted", aborted, 1);
    cmp("t4_busy", busy, 0);
    cmp("t4_ndone", n_done, 1);

    // empty mask and zero mode
    clear_mon();
    sweep(32'h0, 2'd3, 0, -1, -1);
    cmp("t5a_done_lat", t_done - t_start, 2);
    cmp("t5a_nld", n_ld, 0);
    cmp("t5a_count", res_count, 0);
    clear_mon();
    sweep(32'h3, 2'd0, 0, -1, -1);
    cmp("t5b_done_lat", t_done - t_start, 2);
    cmp("t5b_nld", n_ld + n_stw + n_str, 0);

    // reset in the middle of a sweep
    for (int c = 0; c < N; c++) begin dw[c] = 6; dr[c] = 6; end
    clear_mon();
    sweep(32'h6, 2'd3, 0, -1, 15);
    cmp("t6_busy", busy, 0);
    cmp("t6_ndone", n_done, 0);
    repeat (2) tick();

    // random sweeps
    for (int k = 0; k < 25; k++) begin
      m  = $urandom & $urandom & $urandom;
      if ($urandom % 4 == 0) m[31] = 1'b1;
      to = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 15);
      for (int c = 0; c < N; c++) begin
        sw[c] = {$urandom, $urandom};
        sr[c] = {$urandom, $urandom};
        dw[c] = (to != 0 && $urandom % 4 == 0) ? 0 : $urandom_range(1, 12);
        dr[c] = (to != 0 && $urandom % 4 == 0) ? 0 : $urandom_range(1, 12);
      end
      aa = ($urandom % 3 == 0) ? $urandom_range(1, 120) : -1;
      ra = ($urandom % 10 == 0) ? $urandom_range(1, 100) : -1;
      if (ra > 0) aa = -1;
      sweep(m, 2'($urandom), to, aa, ra);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
